// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: first byte of a CS-low frame is an opcode, following bytes are operands.
// Define SPI_INPUT_SYNC_EN to put 2-flop synchronizers on the three SPI pins.
`timescale 1ns/1ps
`default_nettype none

module spi_peripheral (
  input  logic        clock_spi_in,
  input  logic        reset_spi_n_in,
  input  logic        spi_select_n_in,
  input  logic        spi_clock_in,
  input  logic        spi_data_in,
  output logic        spi_data_out,
  output logic [7:0]  op_code_out,
  output logic        op_code_valid_out,
  output logic [7:0]  operand_out,
  output logic        operand_valid_out,
  output logic [31:0] operand_count_out,
  input  logic [7:0]  response_in,
  input  logic        response_valid_in
);

  typedef enum logic [1:0] {IDLE, OPCODE, OPERAND} state_t;

  logic w_cs_pin;
  logic w_sclk_pin;
  logic w_copi_pin;

`ifdef SPI_INPUT_SYNC_EN
  logic [1:0] r_cs_sync;
  logic [1:0] r_sclk_sync;
  logic [1:0] r_copi_sync;

  always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
    if (!reset_spi_n_in) begin
      r_cs_sync   <= 2'b00;
      r_sclk_sync <= 2'b00;
      r_copi_sync <= 2'b00;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], spi_select_n_in};
      r_sclk_sync <= {r_sclk_sync[0], spi_clock_in};
      r_copi_sync <= {r_copi_sync[0], spi_data_in};
    end
  end

  assign w_cs_pin   = r_cs_sync[1];
  assign w_sclk_pin = r_sclk_sync[1];
  assign w_copi_pin = r_copi_sync[1];
`else
  assign w_cs_pin   = spi_select_n_in;
  assign w_sclk_pin = spi_clock_in;
  assign w_copi_pin = spi_data_in;
`endif

  logic r_cs_cur;
  logic r_cs_prev;
  logic r_sclk_cur;
  logic r_sclk_prev;
  logic r_copi_cur;

  // COPI is sampled in the same stage as SCLK so the data bit lines up with its rising edge.
  always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
    if (!reset_spi_n_in) begin
      r_cs_cur    <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_sclk_cur  <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_copi_cur  <= 1'b0;
    end else begin
      r_cs_cur    <= w_cs_pin;
      r_cs_prev   <= r_cs_cur;
      r_sclk_cur  <= w_sclk_pin;
      r_sclk_prev <= r_sclk_cur;
      r_copi_cur  <= w_copi_pin;
    end
  end

  logic w_cs_fall;
  logic w_cs_rise;
  logic w_sclk_rise;
  logic w_sclk_fall;

  assign w_cs_fall   =  r_cs_prev & ~r_cs_cur;
  assign w_cs_rise   = ~r_cs_prev &  r_cs_cur;
  assign w_sclk_rise = ~r_sclk_prev &  r_sclk_cur;
  assign w_sclk_fall =  r_sclk_prev & ~r_sclk_cur;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_tx_shift;
  logic [7:0]  r_op_code;
  logic        r_op_valid;
  logic [7:0]  r_operand;
  logic        r_operand_valid;
  logic [31:0] r_operand_count;
  logic        r_operand_seen;

  logic [7:0]  w_rx_byte;
  assign w_rx_byte = {r_rx_shift[6:0], r_copi_cur};

  always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
    if (!reset_spi_n_in) begin
      r_state         <= IDLE;
      r_bit_cnt       <= 3'd0;
      r_rx_shift      <= 8'h00;
      r_tx_shift      <= 8'h00;
      r_op_code       <= 8'h00;
      r_op_valid      <= 1'b0;
      r_operand       <= 8'h00;
      r_operand_valid <= 1'b0;
      r_operand_count <= 32'd0;
      r_operand_seen  <= 1'b0;
    end else if (w_cs_rise) begin
      // Frame end: drop any partial byte, keep the last opcode/operand values visible.
      r_state         <= IDLE;
      r_bit_cnt       <= 3'd0;
      r_rx_shift      <= 8'h00;
      r_tx_shift      <= 8'h00;
      r_op_valid      <= 1'b0;
      r_operand_valid <= 1'b0;
      r_operand_count <= 32'd0;
      r_operand_seen  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state    <= OPCODE;
            r_tx_shift <= 8'h00;
            if (w_sclk_rise) begin
              r_rx_shift <= {7'd0, r_copi_cur};
              r_bit_cnt  <= 3'd1;
            end else begin
              r_rx_shift <= 8'h00;
              r_bit_cnt  <= 3'd0;
            end
          end
        end

        OPCODE, OPERAND: begin
          if (w_sclk_rise) begin
            r_rx_shift <= w_rx_byte;
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_tx_shift <= 8'h00;
              if (r_state == OPCODE) begin
                r_op_code  <= w_rx_byte;
                r_op_valid <= 1'b1;
                r_state    <= OPERAND;
              end else begin
                r_operand       <= w_rx_byte;
                r_operand_valid <= 1'b1;
                r_operand_seen  <= 1'b1;
                if (r_operand_seen) begin
                  r_operand_count <= r_operand_count + 32'd1;
                end
              end
            end else begin
              r_operand_valid <= 1'b0;
            end
          end else if (w_sclk_fall && (r_bit_cnt != 3'd0)) begin
            // The falling edge after the 8th bit is skipped so a freshly loaded response keeps bit 7.
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end

          if (response_valid_in && (r_bit_cnt == 3'd0)) begin
            r_tx_shift <= response_in;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign spi_data_out      = (r_state == OPERAND) & r_tx_shift[7];
  assign op_code_out       = r_op_code;
  assign op_code_valid_out = r_op_valid;
  assign operand_out       = r_operand;
  assign operand_valid_out = r_operand_valid;
  assign operand_count_out = r_operand_count;

endmodule

`default_nettype wire

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: a bit-banged mode-0 SPI controller drives directed frames,
// expected opcode/operand/CIPO bytes are queued and popped by monitors when the DUT presents them.
`timescale 1ns/1ps

module tb_spi_peripheral;

  logic        clk;
  logic        rst_n;
  logic        spi_select_n_in;
  logic        spi_clock_in;
  logic        spi_data_in;
  logic        spi_data_out;
  logic [7:0]  op_code_out;
  logic        op_code_valid_out;
  logic [7:0]  operand_out;
  logic        operand_valid_out;
  logic [31:0] operand_count_out;
  logic [7:0]  response_in;
  logic        response_valid_in;

  spi_peripheral dut (
    .clock_spi_in      (clk),
    .reset_spi_n_in    (rst_n),
    .spi_select_n_in   (spi_select_n_in),
    .spi_clock_in      (spi_clock_in),
    .spi_data_in       (spi_data_in),
    .spi_data_out      (spi_data_out),
    .op_code_out       (op_code_out),
    .op_code_valid_out (op_code_valid_out),
    .operand_out       (operand_out),
    .operand_valid_out (operand_valid_out),
    .operand_count_out (operand_count_out),
    .response_in       (response_in),
    .response_valid_in (response_valid_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  d;
    logic [31:0] c;
  } opd_t;

  logic [7:0] q_op[$];
  logic [7:0] q_rx[$];
  opd_t       q_opd[$];

  int vectors;
  int miscompares;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT produced 0x%0h with nothing expected at %0t", name, act, $time);
  endtask

  // Monitor: opcode / operand presentation on rising edge of their valid flags.
  logic r_prev_opv;
  logic r_prev_odv;

  always @(negedge clk) begin
    if (op_code_valid_out && !r_prev_opv) begin
      if (q_op.size() == 0) unexpected("op_code", {24'd0, op_code_out});
      else chk("op_code", {24'd0, op_code_out}, {24'd0, q_op.pop_front()});
    end
    if (operand_valid_out && !r_prev_odv) begin
      if (q_opd.size() == 0) unexpected("operand", {24'd0, operand_out});
      else begin
        chk("operand", {24'd0, operand_out}, {24'd0, q_opd[0].d});
        chk("operand_count", operand_count_out, q_opd[0].c);
        void'(q_opd.pop_front());
      end
    end
    r_prev_opv <= op_code_valid_out;
    r_prev_odv <= operand_valid_out;
  end

  // Monitor: CIPO byte as seen by the controller on each SCLK rising edge.
  logic [7:0] r_rx_sh;
  int         r_rx_cnt;

  always @(posedge spi_clock_in or posedge spi_select_n_in or negedge rst_n) begin
    if (!rst_n || spi_select_n_in) begin
      r_rx_cnt <= 0;
      r_rx_sh  <= 8'h00;
    end else begin
      r_rx_sh <= {r_rx_sh[6:0], spi_data_out};
      if (r_rx_cnt == 7) begin
        r_rx_cnt <= 0;
        if (q_rx.size() == 0) unexpected("cipo_byte", {24'd0, r_rx_sh[6:0], spi_data_out});
        else chk("cipo_byte", {24'd0, r_rx_sh[6:0], spi_data_out}, {24'd0, q_rx.pop_front()});
      end else begin
        r_rx_cnt <= r_rx_cnt + 1;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send the top nbits of b MSB first; optionally pulse a response at bit resp_at,
  // optionally drop CS in the same instant as the first SCLK rise.
  task automatic xfer(input logic [7:0] b, input int nbits, input int resp_at,
                      input logic [7:0] resp, input bit cs_same);
    for (int k = 0; k < nbits; k++) begin
      spi_data_in = b[7-k];
      if (k == 0 && cs_same) begin
        spi_select_n_in = 1'b0;
      end else if (k == resp_at) begin
        response_in       = resp;
        response_valid_in = 1'b1;
        wait_clk(1);
        response_valid_in = 1'b0;
        wait_clk(3);
      end else begin
        wait_clk(4);
      end
      spi_clock_in = 1'b1;
      wait_clk(4);
      spi_clock_in = 1'b0;
    end
    wait_clk(4);
  endtask

  task automatic pulse_resp(input logic [7:0] r);
    response_in       = r;
    response_valid_in = 1'b1;
    wait_clk(1);
    response_valid_in = 1'b0;
  endtask

  task automatic cs_low();
    spi_select_n_in = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    spi_select_n_in = 1'b1;
    wait_clk(4);
  endtask

  task automatic exp_opd(input logic [7:0] d, input logic [31:0] c);
    opd_t e;
    e.d = d;
    e.c = c;
    q_opd.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_op_code"},       {24'd0, op_code_out}, 32'd0);
    chk({tag, "_op_valid"},      {31'd0, op_code_valid_out}, 32'd0);
    chk({tag, "_operand"},       {24'd0, operand_out}, 32'd0);
    chk({tag, "_operand_valid"}, {31'd0, operand_valid_out}, 32'd0);
    chk({tag, "_count"},         operand_count_out, 32'd0);
    chk({tag, "_cipo"},          {31'd0, spi_data_out}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vectors           = 0;
    miscompares       = 0;
    rst_n             = 1'b0;
    spi_select_n_in   = 1'b1;
    spi_clock_in      = 1'b0;
    spi_data_in       = 1'b0;
    response_in       = 8'h00;
    response_valid_in = 1'b0;
    wait_clk(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    wait_clk(4);

    // Opcode-only frame.
    cs_low();
    q_rx.push_back(8'h00);
    q_op.push_back(8'h20);
    xfer(8'h20, 8, -1, 8'h00, 1'b0);
    chk("t1_op_valid_held", {31'd0, op_code_valid_out}, 32'd1);
    cs_high();
    chk("t1_op_valid_clr", {31'd0, op_code_valid_out}, 32'd0);
    chk("t1_op_code_held", {24'd0, op_code_out}, 32'h20);
    chk("t1_operand_valid", {31'd0, operand_valid_out}, 32'd0);

    // Response returned on the operand byte, then an unloaded byte returns 0x00.
    cs_low();
    q_rx.push_back(8'h00);
    q_op.push_back(8'h21);
    xfer(8'h21, 8, -1, 8'h00, 1'b0);
    pulse_resp(8'hA5);
    q_rx.push_back(8'hA5);
    exp_opd(8'h00, 32'd0);
    xfer(8'h00, 8, -1, 8'h00, 1'b0);
    q_rx.push_back(8'h00);
    exp_opd(8'h5A, 32'd1);
    xfer(8'h5A, 8, -1, 8'h00, 1'b0);
    cs_high();
    chk("t2_operand_held", {24'd0, operand_out}, 32'h5A);
    chk("t2_count_clr", operand_count_out, 32'd0);

    // Ten operands, count steps 0..9.
    cs_low();
    q_rx.push_back(8'h00);
    q_op.push_back(8'h22);
    xfer(8'h22, 8, -1, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      q_rx.push_back(8'h00);
      exp_opd(i[7:0], i);
      xfer(i[7:0], 8, -1, 8'h00, 1'b0);
    end
    chk("t3_count_last", operand_count_out, 32'd9);
    cs_high();
    chk("t3_count_clr", operand_count_out, 32'd0);

    // CS dropped five bits into the third operand.
    cs_low();
    q_rx.push_back(8'h00);
    q_op.push_back(8'h21);
    xfer(8'h21, 8, -1, 8'h00, 1'b0);
    q_rx.push_back(8'h00);
    exp_opd(8'h44, 32'd0);
    xfer(8'h44, 8, -1, 8'h00, 1'b0);
    q_rx.push_back(8'h00);
    exp_opd(8'h45, 32'd1);
    xfer(8'h45, 8, -1, 8'h00, 1'b0);
    xfer(8'hFF, 5, -1, 8'h00, 1'b0);
    chk("t4_valid_drop_next_byte", {31'd0, operand_valid_out}, 32'd0);
    chk("t4_count_mid", operand_count_out, 32'd1);
    spi_select_n_in = 1'b1;
    wait_clk(2);
    chk("t4_op_valid_clr", {31'd0, op_code_valid_out}, 32'd0);
    chk("t4_count_clr", operand_count_out, 32'd0);
    chk("t4_operand_valid", {31'd0, operand_valid_out}, 32'd0);
    chk("t4_operand_held", {24'd0, operand_out}, 32'h45);
    wait_clk(4);

    // Reset mid-operand; SCLK with CS still low must be ignored until a fresh CS edge.
    cs_low();
    q_rx.push_back(8'h00);
    q_op.push_back(8'h22);
    xfer(8'h22, 8, -1, 8'h00, 1'b0);
    xfer(8'h3C, 3, -1, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_reset");
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    q_rx.push_back(8'h00);
    xfer(8'h55, 8, -1, 8'h00, 1'b0);
    chk("t5_ignored_op_valid", {31'd0, op_code_valid_out}, 32'd0);
    cs_high();
    cs_low();
    q_rx.push_back(8'h00);
    q_op.push_back(8'h21);
    xfer(8'h21, 8, -1, 8'h00, 1'b0);
    q_rx.push_back(8'h00);
    exp_opd(8'h7E, 32'd0);
    xfer(8'h7E, 8, -1, 8'h00, 1'b0);
    cs_high();

    // Response offered mid-byte is dropped.
    cs_low();
    q_rx.push_back(8'h00);
    q_op.push_back(8'h21);
    xfer(8'h21, 8, -1, 8'h00, 1'b0);
    q_rx.push_back(8'h00);
    exp_opd(8'h10, 32'd0);
    xfer(8'h10, 8, 4, 8'hC3, 1'b0);
    q_rx.push_back(8'h00);
    exp_opd(8'h11, 32'd1);
    xfer(8'h11, 8, -1, 8'h00, 1'b0);
    cs_high();

    // CS assert and first SCLK rise arrive together.
    q_rx.push_back(8'h00);
    q_op.push_back(8'h96);
    xfer(8'h96, 8, -1, 8'h00, 1'b1);
    q_rx.push_back(8'h00);
    exp_opd(8'h69, 32'd0);
    xfer(8'h69, 8, -1, 8'h00, 1'b0);
    cs_high();

    wait_clk(10);
    chk("q_op_left", q_op.size(), 32'd0);
    chk("q_opd_left", q_opd.size(), 32'd0);
    chk("q_rx_left", q_rx.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
